// File: rtl/shift_seq.sv
// Command sequencer that drives an external enable-less N-bit shift register
// through a load / shift-N / done cycle, with abort and async reset.
module shift_seq #(
   parameter int unsigned N    = 4,
   parameter int unsigned CNTW = 3
) (
   input  logic            clock,
   input  logic            resetn,
   input  logic            start,
   input  logic            load_first,
   input  logic [N-1:0]    data_in,
   input  logic            dir_in,
   input  logic            rotate_in,
   input  logic            fill_in,
   input  logic [CNTW-1:0] count,
   input  logic            abort,
   input  logic [N-1:0]    q,
   output logic            L,
   output logic [N-1:0]    R,
   output logic            dir,
   output logic            w0,
   output logic            w1,
   output logic            busy,
   output logic            done,
   output logic [CNTW-1:0] shifts_left
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      SHIFT = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic [N-1:0]      data_r;
   logic              dir_r;
   logic              rot_r;
   logic              fill_r;
   logic [CNTW-1:0]   cnt_r;

   // State register
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) state <= IDLE;
      else         state <= state_nxt;
   end

   // Captured command fields and the remaining-shift counter
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         data_r <= '0;
         dir_r  <= 1'b0;
         rot_r  <= 1'b0;
         fill_r <= 1'b0;
         cnt_r  <= '0;
      end else if (state == IDLE && start) begin
         data_r <= data_in;
         dir_r  <= dir_in;
         rot_r  <= rotate_in;
         fill_r <= fill_in;
         cnt_r  <= count;
      end else if ((state == LOAD || state == SHIFT) && abort) begin
         cnt_r  <= '0;
      end else if (state == SHIFT) begin
         cnt_r  <= cnt_r - CNTW'(1);
      end
   end

   // Next-state logic; abort takes priority over the final shift edge
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: begin
            if (start) begin
               if (load_first)       state_nxt = LOAD;
               else if (count != '0) state_nxt = SHIFT;
               else                  state_nxt = DONE;
            end
         end
         LOAD: begin
            if (abort)              state_nxt = IDLE;
            else if (cnt_r != '0)   state_nxt = SHIFT;
            else                    state_nxt = DONE;
         end
         SHIFT: begin
            if (abort)                   state_nxt = IDLE;
            else if (cnt_r <= CNTW'(1))  state_nxt = DONE;
            else                         state_nxt = SHIFT;
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Moore output decode; non-SHIFT states keep the register loading itself
   always_comb begin
      L           = 1'b1;
      R           = q;
      dir         = 1'b0;
      w0          = 1'b0;
      w1          = 1'b0;
      busy        = (state != IDLE);
      done        = (state == DONE);
      shifts_left = (state == IDLE) ? '0 : cnt_r;
      unique case (state)
         LOAD: R = data_r;
         SHIFT: begin
            L   = 1'b0;
            dir = dir_r;
            w0  = rot_r ? q[0]   : fill_r;
            w1  = rot_r ? q[N-1] : fill_r;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_shift_seq.sv
// Scoreboard bench for shift_seq driving a behavioural 4-bit shift register.
module tb_shift_seq;

   localparam int unsigned N    = 4;
   localparam int unsigned CNTW = 3;

   logic            clock;
   logic            resetn;
   logic            start;
   logic            load_first;
   logic [N-1:0]    data_in;
   logic            dir_in;
   logic            rotate_in;
   logic            fill_in;
   logic [CNTW-1:0] count;
   logic            abort;
   logic [N-1:0]    q;
   logic            L;
   logic [N-1:0]    R;
   logic            dir;
   logic            w0;
   logic            w1;
   logic            busy;
   logic            done;
   logic [CNTW-1:0] shifts_left;

   typedef struct {
      logic [N-1:0] qv;
      int           busy_cycles;
      int           shift_cycles;
   } exp_t;

   exp_t sb[$];
   int   errors = 0;
   int   checks = 0;
   int   bcnt   = 0;
   int   scnt   = 0;

   shift_seq #(.N(N), .CNTW(CNTW)) dut (
      .clock(clock), .resetn(resetn), .start(start), .load_first(load_first),
      .data_in(data_in), .dir_in(dir_in), .rotate_in(rotate_in), .fill_in(fill_in),
      .count(count), .abort(abort), .q(q), .L(L), .R(R), .dir(dir), .w0(w0),
      .w1(w1), .busy(busy), .done(done), .shifts_left(shifts_left)
   );

   // Controlled register: no enable, no reset
   always @(posedge clock) begin
      if (L)        q <= R;
      else if (dir) q <= {w0, q[N-1:1]};
      else          q <= {q[N-2:0], w1};
   end

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: sim time limit reached, got no finish, need finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, need %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic push(input logic [N-1:0] qv, input int b, input int s);
      exp_t e;
      e.qv = qv; e.busy_cycles = b; e.shift_cycles = s;
      sb.push_back(e);
   endtask

   task automatic set_cmd(input logic lf, input logic [N-1:0] d, input logic dr,
                          input logic rot, input logic fl, input logic [CNTW-1:0] c);
      load_first = lf; data_in = d; dir_in = dr; rotate_in = rot; fill_in = fl; count = c;
   endtask

   task automatic issue(input logic lf, input logic [N-1:0] d, input logic dr,
                        input logic rot, input logic fl, input logic [CNTW-1:0] c);
      @(negedge clock);
      set_cmd(lf, d, dr, rot, fl, c);
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      int n = 0;
      while (busy && n < 64) begin
         @(negedge clock);
         n++;
      end
      if (busy) chk(name, 32'(busy), 32'(0));
   endtask

   // Monitor: measure each command's busy/shift length, compare on done
   always @(negedge clock) begin
      exp_t e;
      if (!resetn) begin
         bcnt = 0; scnt = 0;
      end else begin
         if (busy) begin
            bcnt++;
            if (!L) scnt++;
         end
         if (done) begin
            if (sb.size() == 0) begin
               chk("unexpected_done", 32'(done), 32'(0));
            end else begin
               e = sb.pop_front();
               chk("done_q",      32'(q),    32'(e.qv));
               chk("busy_cycles", 32'(bcnt), 32'(e.busy_cycles));
               chk("shift_cycles", 32'(scnt), 32'(e.shift_cycles));
            end
         end
         if (!busy || done) begin
            bcnt = 0; scnt = 0;
         end
      end
   end

   initial begin
      resetn = 1'b0; start = 1'b0; abort = 1'b0;
      set_cmd(1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 3'd0);
      #12;
      chk("rst_L",      32'(L),           32'(1));
      chk("rst_R_eq_q", 32'(R == q),      32'(1));
      chk("rst_busy",   32'(busy),        32'(0));
      chk("rst_done",   32'(done),        32'(0));
      chk("rst_dirw",   32'({dir, w0, w1}), 32'(0));
      chk("rst_left",   32'(shifts_left), 32'(0));
      @(negedge clock);
      resetn = 1'b1;

      // Load 1011, shift right 2 with fill 0
      push(4'b0010, 4, 2);
      issue(1'b1, 4'b1011, 1'b1, 1'b0, 1'b0, 3'd2);
      wait_idle("wait_t1");
      for (int i = 0; i < 10; i++) begin
         @(negedge clock);
         chk("hold_q", 32'(q), 32'(4'b0010));
      end

      // Restore 1011 (zero-count load), then rotate left 1 and 3
      push(4'b1011, 2, 0);
      issue(1'b1, 4'b1011, 1'b0, 1'b0, 1'b0, 3'd0);
      wait_idle("wait_t2a");
      push(4'b0111, 2, 1);
      issue(1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 3'd1);
      wait_idle("wait_t2b");
      push(4'b1011, 4, 3);
      issue(1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 3'd3);
      wait_idle("wait_t2c");

      // Zero-count load of 0110
      push(4'b0110, 2, 0);
      issue(1'b1, 4'b0110, 1'b0, 1'b0, 1'b0, 3'd0);
      wait_idle("wait_t3");

      // Abort in the second SHIFT cycle of a left-shift-4 after loading 1111
      issue(1'b1, 4'b1111, 1'b0, 1'b0, 1'b0, 3'd4);
      @(negedge clock);
      chk("abort_left4", 32'(shifts_left), 32'(4));
      @(negedge clock);
      chk("abort_left3", 32'(shifts_left), 32'(3));
      abort = 1'b1;
      @(negedge clock);
      abort = 1'b0;
      chk("abort_busy", 32'(busy),        32'(0));
      chk("abort_q",    32'(q),           32'(4'b1100));
      chk("abort_left", 32'(shifts_left), 32'(0));
      repeat (2) @(negedge clock);
      chk("abort_hold", 32'(q), 32'(4'b1100));

      // start held high: second command accepted only in first IDLE after done
      push(4'b0110, 2, 1);
      push(4'b1011, 3, 2);
      @(negedge clock);
      set_cmd(1'b0, 4'b0000, 1'b1, 1'b1, 1'b0, 3'd1);
      start = 1'b1;
      @(negedge clock);
      set_cmd(1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 3'd2);
      @(negedge clock);
      chk("bp_done",    32'(done), 32'(1));
      @(negedge clock);
      chk("bp_idle",    32'(busy), 32'(0));
      @(negedge clock);
      chk("bp_accept",  32'(busy), 32'(1));
      start = 1'b0;
      wait_idle("wait_t5");

      // Async reset mid-SHIFT
      issue(1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 3'd5);
      repeat (2) @(negedge clock);
      chk("pre_rst_q", 32'(q), 32'(4'b0010));
      #2 resetn = 1'b0;
      #1;
      chk("arst_busy", 32'(busy),        32'(0));
      chk("arst_L",    32'(L),           32'(1));
      chk("arst_left", 32'(shifts_left), 32'(0));
      chk("arst_done", 32'(done),        32'(0));
      @(negedge clock);
      resetn = 1'b1;
      @(negedge clock);
      chk("post_rst_q",    32'(q),    32'(4'b0010));
      chk("post_rst_busy", 32'(busy), 32'(0));
      repeat (3) @(negedge clock);
      chk("post_rst_hold", 32'(q), 32'(4'b0010));

      chk("pending", 32'(sb.size()), 32'(0));
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/shift_seq.md
SHIFT_SEQ -- requirements
Module: shift_seq

Interface
REQ-001 SHALL have parameter N, default 4, width of the controlled shift register.
REQ-002 SHALL have parameter CNTW, default 3, width of the shift-count field.
REQ-003 SHALL have port clock  input  1  single clock; all state changes on the rising edge.
REQ-004 SHALL have port resetn  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  command request; sampled only in IDLE.
REQ-006 SHALL have port load_first  input  1  command: parallel-load data_in before shifting.
REQ-007 SHALL have port data_in  input  N  command: value to load.
REQ-008 SHALL have port dir_in  input  1  command: 1 = shift right, 0 = shift left.
REQ-009 SHALL have port rotate_in  input  1  command: 1 = rotate, 0 = shift in fill_in.
REQ-010 SHALL have port fill_in  input  1  command: serial fill bit when rotate_in=0.
REQ-011 SHALL have port count  input  CNTW  command: number of shift cycles, 0..2^CNTW-1.
REQ-012 SHALL have port abort  input  1  cancels an active command.
REQ-013 SHALL have port q  input  N  current contents of the controlled register.
REQ-014 SHALL have port L  output  1  register parallel-load control.
REQ-015 SHALL have port R  output  N  register parallel-load value.
REQ-016 SHALL have port dir  output  1  register shift direction.
REQ-017 SHALL have port w0  output  1  serial input to MSB on right shift.
REQ-018 SHALL have port w1  output  1  serial input to LSB on left shift.
REQ-019 SHALL have port busy  output  1  high in any state except IDLE.
REQ-020 SHALL have port done  output  1  one-cycle completion pulse.
REQ-021 SHALL have port shifts_left  output  CNTW  remaining shift cycles.

Function
REQ-022 SHALL implement a Moore FSM with states IDLE, LOAD, SHIFT and DONE; all outputs SHALL decode from the registered state and registered command fields.
REQ-023 The controlled register has no enable and shifts on every edge with L=0, so every state other than SHIFT SHALL drive L=1.
REQ-024 IDLE and DONE SHALL drive L=1 and R=q, so the register holds its value by reloading itself.
REQ-025 In IDLE with start=1, the block SHALL capture data_in, dir_in, rotate_in, fill_in and count into internal registers on the same edge.
REQ-026 Next state after IDLE with start=1 SHALL be: LOAD if load_first=1; else SHIFT if count>0; else DONE.
REQ-027 LOAD SHALL last exactly one cycle with L=1 and R=captured data.
REQ-028 Next state after LOAD SHALL be SHIFT if captured count>0, else DONE.
REQ-029 SHIFT SHALL drive L=0 and dir=captured direction.
REQ-030 In SHIFT, w0 SHALL be q[0] if rotate else fill, and w1 SHALL be q[N-1] if rotate else fill.
REQ-031 The counter SHALL decrement on each SHIFT edge; at the edge where it goes 1->0, the next state SHALL be DONE.
REQ-032 SHIFT SHALL therefore last exactly count cycles.
REQ-033 DONE SHALL last one cycle with done=1, then the FSM SHALL return to IDLE.
REQ-034 start SHALL be ignored while busy=1; no command is queued.
REQ-035 abort=1 in LOAD or SHIFT SHALL move the FSM to IDLE on the next edge, with no done pulse.
REQ-036 abort SHALL be ignored in IDLE and DONE.
REQ-037 When abort=1 and the final shift edge coincide, abort SHALL win.
REQ-038 dir, w0 and w1 SHALL be 0 outside SHIFT.
REQ-039 shifts_left SHALL show the counter value, and SHALL be 0 in IDLE.
REQ-040 count values greater than N SHALL be honoured literally, with no clamping.

Reset
REQ-041 resetn=0 SHALL force IDLE immediately, asynchronously.
REQ-042 During reset, outputs SHALL be L=1, R=q, dir=0, w0=0, w1=0, busy=0, done=0 and shifts_left=0, and all captured command registers SHALL be cleared.
REQ-043 Reset asserted mid-command SHALL discard the command with no done pulse; the register keeps whatever value was loaded at the last edge.

Verification
The bench instantiates the team's nshift register with n=N=4, wired to L, R, dir, w0, w1 and q.
REQ-044 Load and right shift: load 1011, shift right 2 with fill 0 -> q=0010; busy high for 4 cycles; done pulses once; q holds 0010 for 10 idle cycles.
REQ-045 Rotate left: with q=1011 and no load, rotate left 1 -> q=0111; rotate left 3 more -> q=1011.
REQ-046 Zero-count load: load_first=1, count=0, data 0110 -> LOAD then DONE, q=0110; no L=0 cycle observed.
REQ-047 Abort: load 1111, shift left 4 with fill 0, abort in the 2nd SHIFT cycle -> q=1100, done never pulses, IDLE on the next cycle.
REQ-048 Back-pressure: start held high throughout a command -> a second command is accepted only in the first IDLE cycle after done.
REQ-049 Async reset: resetn low mid-SHIFT, between edges -> busy=0 and L=1 immediately; after release the FSM is in IDLE and q is unchanged.
